// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice reused over N = WIDTH/CHUNK
// cycles, with the inter-chunk carry held in a register and valid/ready on both sides.

module seq_addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[CHUNK];
endmodule

module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] res_next;

  assign slice_a = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign slice_b = b_q[int'(cnt_q)*CHUNK +: CHUNK];

  seq_addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Partial result with the current chunk merged in; on the last chunk this is the final sum.
  always_comb begin
    res_next = res_q;
    res_next[int'(cnt_q)*CHUNK +: CHUNK] = slice_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d = HOLD;
          sum_d   = res_next;
          c_out_d = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: three instances (CHUNK=4, 1, 16) checked every cycle against an
// arithmetic/latency model, plus hand-computed expectations for the directed cases.

module tb_seq_addsub;
  localparam int W  = 16;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NI-1:0]   in_valid, out_ready, c_in, sub;
  logic [W-1:0]    a_w [NI];
  logic [W-1:0]    b_w [NI];
  logic            in_ready_w [NI];
  logic            out_valid_w [NI];
  logic            c_out_w [NI];
  logic            ovf_w [NI];
  logic [W-1:0]    sum_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    seq_addsub #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_w[g]),
      .a         (a_w[g]),
      .b         (b_w[g]),
      .c_in      (c_in[g]),
      .sub       (sub[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_w[g]),
      .c_out     (c_out_w[g]),
      .ovf       (ovf_w[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
  endfunction

  function automatic logic [17:0] pk(input bit ov, input bit co, input logic [15:0] s);
    return {ov, co, s};
  endfunction

  // Reference: plain integer arithmetic; result packed as {ovf, c_out, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sb);
    int          ua, ub, sa, sbv, s;
    logic [31:0] t;
    bit          co;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      t  = 32'(ua - ub);
      co = (ua >= ub);
      s  = sa - sbv;
    end else begin
      t  = 32'(ua + ub + int'(cin));
      co = t[16];
      s  = sa + sbv + int'(cin);
    end
    return pk((s > 32767) || (s < -32768), co, t[15:0]);
  endfunction

  // Counters and model state are written only by the compare process.
  int          n_tests = 0, n_fail = 0, cyc = 0;
  int          tmo_cnt = 0, tmo_seen = 0;
  bit          m_init [NI], m_idle [NI], m_hold [NI], prev_ov [NI];
  int          m_cd [NI], acc_cyc [NI];
  logic [17:0] m_out [NI], m_pend [NI];
  int          lit_req [NI], lit_ack [NI], lit_lat [NI];
  logic [17:0] lit_val [NI];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (tmo_cnt != tmo_seen) begin
      chk("bounded_wait", 0, 32'(tmo_cnt), 32'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
    for (int k = 0; k < NI; k++) begin
      if (m_init[k]) begin
        chk("in_ready",  k, 32'(in_ready_w[k]),  32'(m_idle[k]));
        chk("out_valid", k, 32'(out_valid_w[k]), 32'(m_hold[k]));
        chk("sum",       k, 32'(sum_w[k]),       32'(m_out[k][15:0]));
        chk("c_out",     k, 32'(c_out_w[k]),     32'(m_out[k][16]));
        chk("ovf",       k, 32'(ovf_w[k]),       32'(m_out[k][17]));
        if (out_valid_w[k] === 1'b1 && !prev_ov[k] && lit_req[k] != lit_ack[k]) begin
          chk("latency",   k, 32'(cyc - acc_cyc[k]),               32'(lit_lat[k]));
          chk("lit_result", k, 32'({ovf_w[k], c_out_w[k], sum_w[k]}), 32'(lit_val[k]));
          chk("lit_model", k, 32'(m_out[k]),                       32'(lit_val[k]));
          lit_ack[k] = lit_req[k];
        end
      end
      prev_ov[k] = (out_valid_w[k] === 1'b1);
      // Advance the model to what the coming rising edge must produce.
      if (rst) begin
        m_init[k] = 1'b1;
        m_idle[k] = 1'b1;
        m_hold[k] = 1'b0;
        m_cd[k]   = 0;
        m_out[k]  = '0;
      end else if (m_init[k]) begin
        if (m_idle[k]) begin
          if (in_valid[k]) begin
            m_pend[k]  = ref_op(a_w[k], b_w[k], c_in[k], sub[k]);
            m_cd[k]    = lat_of(k);
            m_idle[k]  = 1'b0;
            acc_cyc[k] = cyc + 1;
          end
        end else if (m_cd[k] > 0) begin
          m_cd[k]--;
          if (m_cd[k] == 0) begin
            m_hold[k] = 1'b1;
            m_out[k]  = m_pend[k];
          end
        end else if (m_hold[k] && out_ready[k]) begin
          m_hold[k] = 1'b0;
          m_idle[k] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] rnd16();
    case ($urandom_range(5))
      0: return 16'hFFFF;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sb);
    a_w[k] = a; b_w[k] = b; c_in[k] = cin; sub[k] = sb; in_valid[k] = 1'b1;
  endtask

  task automatic wait_accept(input int k);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready_w[k] === 1'b1) got = 1;
    end
    if (!got) tmo_cnt++;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_valid_w[k] === 1'b1) got = 1;
    end
    if (!got) tmo_cnt++;
  endtask

  task automatic handshake(input int k);
    @(posedge clk); #1 out_ready[k] = 1'b1;
    @(posedge clk); #1 out_ready[k] = 1'b0;
  endtask

  task automatic set_lit(input int k, input logic [17:0] v);
    lit_val[k] = v;
    lit_lat[k] = lat_of(k);
    lit_req[k] = lit_req[k] + 1;
  endtask

  task automatic run_lit(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sb, input logic [17:0] v);
    set_lit(k, v);
    drive(k, a, b, cin, sb);
    wait_accept(k);
    wait_out(k);
    handshake(k);
  endtask

  logic [15:0] ta [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0005, 16'h8000};
  logic [15:0] tb [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0007, 16'h0001};
  logic        tc [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [17:0] tx [7];

  initial begin
    tx[0] = pk(0, 0, 16'h5556);
    tx[1] = pk(0, 1, 16'h0000);
    tx[2] = pk(1, 0, 16'h8000);
    tx[3] = pk(0, 0, 16'hFFFE);
    tx[4] = pk(1, 1, 16'h7FFF);
    tx[5] = pk(0, 0, 16'hFFFE);
    tx[6] = pk(1, 1, 16'h7FFF);

    // Reset held two edges with requests pending: nothing may be accepted.
    rst = 1'b1; out_ready = '0; c_in = '0; sub = '0; in_valid = '1;
    for (int k = 0; k < NI; k++) begin a_w[k] = 16'h1234; b_w[k] = 16'h4321; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Directed arithmetic on every chunking.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 7; i++)
        run_lit(k, ta[i], tb[i], tc[i], ts[i], tx[i]);

    // Backpressure: result stalls six cycles while a second op waits.
    run_lit(0, 16'h0001, 16'h0001, 1'b0, 1'b0, pk(0, 0, 16'h0002));
    set_lit(0, pk(0, 0, 16'h5556));
    drive(0, 16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_accept(0);
    wait_out(0);
    @(posedge clk); #1;
    set_lit(0, pk(0, 0, 16'h0002));
    drive(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(posedge clk); #1 out_ready[0] = 1'b0;
    wait_accept(0);
    wait_out(0);
    handshake(0);

    // Abort: reset on the second RUN edge discards the op.
    drive(0, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
    wait_accept(0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    run_lit(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, pk(0, 0, 16'h0100));

    // Random traffic with random backpressure; operands may change after accept.
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 300; c++) begin
        bit acc;
        @(negedge clk);
        acc = in_valid[k] && (in_ready_w[k] === 1'b1);
        @(posedge clk); #1;
        if (!in_valid[k] || acc) begin
          if ($urandom_range(2) != 0)
            drive(k, rnd16(), rnd16(), 1'($urandom_range(1)), 1'($urandom_range(1)));
          else
            in_valid[k] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          in_valid[k] = 1'b1;
        end
        out_ready[k] = 1'($urandom_range(1));
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      repeat (25) @(posedge clk);
      #1 out_ready[k] = 1'b0;
    end

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, processing CHUNK bits per clock through a CHUNK-bit ripple slice, with the carry held in a register between chunks.
- Valid/ready handshakes on the operand and result sides; also reports carry-out and signed overflow.
- Sits in the datapath wherever a wide add is needed but a full-width ripple chain would not meet timing or area.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 1.
- CHUNK, 4, bits processed per cycle; must be >= 1 and divide WIDTH evenly; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+c_in; 1: A-B, i.e. A+~B+1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- c_out  output  1  raw carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE and the chunk counter and carry register clear.
  - in_ready=1; out_valid=0; sum=0; c_out=0; ovf=0.
  - Reset wins over every other input, including reset mid-RUN or mid-HOLD: the operation in flight is discarded and no result is produced.
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch a, b_eff (= sub ? ~b : b) and carry (= sub ? 1 : c_in).
  - Counter clears to 0; state goes to RUN.
- RUN:
  - in_ready=0.
  - Each edge adds the chunk at index cnt of a and b_eff with the carry register, starting from the LSB chunk.
  - Stores the chunk sum into the internal result, updates the carry register and increments cnt.
  - On the edge where cnt = N-1, state goes to HOLD and the visible sum/c_out/ovf registers load.
- HOLD:
  - out_valid=1; sum, c_out and ovf stay stable.
  - On out_ready=1, state goes to IDLE.
  - in_ready stays 0 throughout HOLD. A new operation is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises exactly N cycles after the accept edge; throughput is one operation per N+2 cycles at best.
- sum, c_out and ovf change only at the completing edge or at reset. They hold their values after the handshake until the next completion.
- ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) and (sum[WIDTH-1] != a[WIDTH-1]).
- c_out is the carry out of the top chunk; no wider result is produced, and arithmetic wraps modulo 2^WIDTH.
- Operand inputs are sampled only at the accept edge; changes during RUN or HOLD have no effect.
- in_valid with in_ready=0 is ignored; upstream holds its request.
- Degenerate settings are legal:
  - CHUNK=WIDTH (N=1): RUN lasts one cycle.
  - CHUNK=1: bit-serial operation.

Test Plan (WIDTH=16, CHUNK=4, N=4 unless stated):
1. Reset: hold rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, sum=0x0000, c_out=0, ovf=0, and nothing accepted.
2. Basic add, a=0x1234, b=0x4321, c_in=1, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x5556, c_out=0, ovf=0.
3. Add boundaries:
   - 0xFFFF+0x0001 (c_in=0) -> sum=0x0000, c_out=1, ovf=0.
   - 0x7FFF+0x0001 -> sum=0x8000, c_out=0, ovf=1.
4. Subtract:
   - 0x0005-0x0007 -> sum=0xFFFE, c_out=0, ovf=0.
   - 0x8000-0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
   - c_in=1 with sub=1 gives the same results (c_in ignored).
5. Backpressure:
   - Setup: hold out_ready=0 for 6 cycles after out_valid rises, with a second op (0x0001+0x0001) held on in_valid.
   - Expected during stall: sum, c_out and ovf stable; in_ready=0.
   - After out_ready=1: the second op is accepted the following cycle and gives sum=0x0002 four cycles later.
6. Abort and parameter sweep:
   - Assert rst on the 2nd RUN cycle -> next cycle IDLE, out_valid never rises, sum=0; a fresh op 0x00FF+0x0001 then gives 0x0100.
   - Repeat scenarios 2-4 with CHUNK=1 (latency 16) and CHUNK=16 (latency 1) with identical results.
